// File: rtl/v810_exc_seq_pkg.sv
// V810 exception sequencer shared types.
// PSW/ECR layouts, sysreg selects, vectors.
package v810_exc_seq_pkg;

    typedef struct packed {
        logic [11:0] rsv;
        logic [3:0]  i;
        logic        np;
        logic        ep;
        logic        ae;
        logic        id;
        logic [11:0] flags;
    } psw_t;

    typedef struct packed {
        logic [15:0] fecc;
        logic [15:0] eicc;
    } ecr_t;

    localparam logic [4:0] SRSEL_EIPC  = 5'd0;
    localparam logic [4:0] SRSEL_EIPSW = 5'd1;
    localparam logic [4:0] SRSEL_FEPC  = 5'd2;
    localparam logic [4:0] SRSEL_FEPSW = 5'd3;
    localparam logic [4:0] SRSEL_ECR   = 5'd4;
    localparam logic [4:0] SRSEL_PSW   = 5'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE_PC,
        ST_SAVE_PSW,
        ST_REDIR,
        ST_RETI_PC,
        ST_RETI_PSW,
        ST_FATAL
    } EXC_STATE_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_EXC,
        REQ_RETI,
        REQ_INT
    } req_kind_t;

    localparam logic [15:0] INT_CODE_BASE = 16'hFE00;
    localparam logic [31:0] VEC_BASE      = 32'hFFFF0000;
    localparam logic [31:0] VEC_DUPLEX    = 32'hFFFFFFD0;

    function automatic logic [15:0] int_code(
        input logic [3:0] lvl
    );
        return INT_CODE_BASE | {8'h00, lvl, 4'h0};
    endfunction

    function automatic logic [3:0] int_next_level(
        input logic [3:0] lvl
    );
        return (lvl == 4'hF) ? 4'hF : lvl + 4'd1;
    endfunction

    function automatic logic [31:0] vec_target(
        input logic [15:0] code
    );
        return VEC_BASE | {16'h0000, code[15:4], 4'h0};
    endfunction

endpackage

// File: rtl/v810_int_accept.sv
// V810 request arbiter: interrupt mask/level
// compare and EXC > RETI > INT priority pick.
module v810_int_accept
    import v810_exc_seq_pkg::*;
(
    input  logic       exc_req,
    input  logic       reti_req,
    input  logic       int_req,
    input  logic [3:0] int_level,
    input  logic       psw_np,
    input  logic       psw_ep,
    input  logic       psw_id,
    input  logic [3:0] psw_i,
    output req_kind_t  kind
);

    logic int_ok;

    assign int_ok = int_req & ~psw_np & ~psw_ep
                  & ~psw_id & (int_level >= psw_i);

    // Mutually exclusive priority terms
    always_comb begin
        kind = REQ_NONE;
        unique case (1'b1)
            exc_req:
                kind = REQ_EXC;
            (~exc_req & reti_req):
                kind = REQ_RETI;
            (~exc_req & ~reti_req & int_ok):
                kind = REQ_INT;
            default:
                kind = REQ_NONE;
        endcase
    end

endmodule

// File: rtl/v810_exc_seq.sv
// V810 exception/interrupt/RETI sequencer.
// Saves context, updates PSW/ECR, redirects fetch.
module v810_exc_seq
    import v810_exc_seq_pkg::*;
#(
    parameter bit FATAL_HALT = 1'b1
)
(
    input  logic        CLK,
    input  logic        RESn,
    input  logic        CE,
    input  logic        EXC_REQ,
    input  logic [15:0] EXC_CODE,
    input  logic [31:0] EXC_PC,
    input  logic        INT_REQ,
    input  logic [3:0]  INT_LEVEL,
    input  logic [31:0] INT_PC,
    input  logic        RETI_REQ,
    output logic        EXC_ACK,
    output logic        STALL,
    input  psw_t        PSW,
    output logic [4:0]  SR_RA,
    input  logic [31:0] SR_RD,
    output logic [4:0]  SR_WA,
    output logic [31:0] SR_WD,
    output logic        SR_WE,
    output psw_t        PSW_SET,
    output psw_t        PSW_RESET,
    output logic [15:0] ECR_CC,
    output logic        ECR_SET_EICC,
    output logic        ECR_SET_FECC,
    output logic        BR_REQ,
    output logic [31:0] BR_TGT,
    input  logic        BR_ACK,
    output logic        FATAL
);

    EXC_STATE_t  state;
    req_kind_t   kind;

    logic        ack_r;
    logic        stall_r;
    logic [4:0]  ra_r;
    logic [4:0]  wa_r;
    logic [31:0] wd_r;
    logic        we_r;
    psw_t        set_r;
    psw_t        rst_r;
    logic [15:0] cc_r;
    logic        eicc_r;
    logic        fecc_r;
    logic        brq_r;
    logic [31:0] tgt_r;
    logic        fatal_r;
    logic [15:0] code_r;
    logic        dup_r;
    logic        int_r;
    logic [3:0]  lvl_r;
    logic        np_r;

    v810_int_accept u_accept (
        .exc_req   (EXC_REQ),
        .reti_req  (RETI_REQ),
        .int_req   (INT_REQ),
        .int_level (INT_LEVEL),
        .psw_np    (PSW.np),
        .psw_ep    (PSW.ep),
        .psw_id    (PSW.id),
        .psw_i     (PSW.i),
        .kind      (kind)
    );

    assign EXC_ACK      = ack_r;
    assign STALL        = stall_r;
    assign SR_RA        = ra_r;
    assign SR_WA        = wa_r;
    assign SR_WD        = (state == ST_RETI_PSW)
                        ? SR_RD : wd_r;
    assign SR_WE        = we_r & CE;
    assign PSW_SET      = CE ? set_r : '0;
    assign PSW_RESET    = CE ? rst_r : '0;
    assign ECR_CC       = cc_r;
    assign ECR_SET_EICC = eicc_r & CE;
    assign ECR_SET_FECC = fecc_r & CE;
    assign BR_REQ       = brq_r;
    assign BR_TGT       = tgt_r;
    assign FATAL        = fatal_r;

    // Sequencer FSM; outputs registered for the state being entered
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state   <= ST_IDLE;
            ack_r   <= 1'b0;
            stall_r <= 1'b0;
            ra_r    <= '0;
            wa_r    <= '0;
            wd_r    <= '0;
            we_r    <= 1'b0;
            set_r   <= '0;
            rst_r   <= '0;
            cc_r    <= '0;
            eicc_r  <= 1'b0;
            fecc_r  <= 1'b0;
            brq_r   <= 1'b0;
            tgt_r   <= '0;
            fatal_r <= 1'b0;
            code_r  <= '0;
            dup_r   <= 1'b0;
            int_r   <= 1'b0;
            lvl_r   <= '0;
            np_r    <= 1'b0;
        end else if (CE) begin
            ack_r  <= 1'b0;
            we_r   <= 1'b0;
            set_r  <= '0;
            rst_r  <= '0;
            cc_r   <= '0;
            eicc_r <= 1'b0;
            fecc_r <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    unique case (kind)
                        REQ_EXC: begin
                            ack_r   <= 1'b1;
                            stall_r <= 1'b1;
                            code_r  <= EXC_CODE;
                            int_r   <= 1'b0;
                            dup_r   <= PSW.np | PSW.ep;
                            if (PSW.np && FATAL_HALT) begin
                                fatal_r <= 1'b1;
                                state   <= ST_FATAL;
                            end else begin
                                we_r  <= 1'b1;
                                wa_r  <= (PSW.np | PSW.ep)
                                       ? SRSEL_FEPC
                                       : SRSEL_EIPC;
                                wd_r  <= EXC_PC;
                                state <= ST_SAVE_PC;
                            end
                        end
                        REQ_INT: begin
                            ack_r   <= 1'b1;
                            stall_r <= 1'b1;
                            code_r  <= int_code(INT_LEVEL);
                            lvl_r   <= INT_LEVEL;
                            int_r   <= 1'b1;
                            dup_r   <= 1'b0;
                            we_r    <= 1'b1;
                            wa_r    <= SRSEL_EIPC;
                            wd_r    <= INT_PC;
                            state   <= ST_SAVE_PC;
                        end
                        REQ_RETI: begin
                            ack_r   <= 1'b1;
                            stall_r <= 1'b1;
                            np_r    <= PSW.np;
                            ra_r    <= PSW.np ? SRSEL_FEPC
                                              : SRSEL_EIPC;
                            state   <= ST_RETI_PC;
                        end
                        default: ;
                    endcase
                end
                ST_SAVE_PC: begin
                    we_r     <= 1'b1;
                    wa_r     <= dup_r ? SRSEL_FEPSW
                                      : SRSEL_EIPSW;
                    wd_r     <= PSW;
                    cc_r     <= code_r;
                    eicc_r   <= ~dup_r;
                    fecc_r   <= dup_r;
                    set_r.np <= dup_r;
                    set_r.ep <= ~dup_r;
                    set_r.id <= 1'b1;
                    rst_r.ae <= 1'b1;
                    if (int_r) begin
                        set_r.i <= int_next_level(lvl_r);
                        rst_r.i <= 4'hF;
                    end
                    state    <= ST_SAVE_PSW;
                end
                ST_SAVE_PSW: begin
                    wa_r  <= '0;
                    wd_r  <= '0;
                    brq_r <= 1'b1;
                    tgt_r <= dup_r ? VEC_DUPLEX
                                   : vec_target(code_r);
                    state <= ST_REDIR;
                end
                ST_RETI_PC: begin
                    tgt_r <= SR_RD & ~32'h1;
                    ra_r  <= np_r ? SRSEL_FEPSW
                                  : SRSEL_EIPSW;
                    we_r  <= 1'b1;
                    wa_r  <= SRSEL_PSW;
                    state <= ST_RETI_PSW;
                end
                ST_RETI_PSW: begin
                    ra_r  <= '0;
                    wa_r  <= '0;
                    brq_r <= 1'b1;
                    state <= ST_REDIR;
                end
                ST_REDIR: begin
                    if (BR_ACK) begin
                        brq_r   <= 1'b0;
                        stall_r <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_FATAL: begin
                    fatal_r <= 1'b1;
                    stall_r <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_v810_exc_seq.sv
// Directed bench for v810_exc_seq with a sysreg
// model and an expected-value queue.
module tb_v810_exc_seq;
    import v810_exc_seq_pkg::*;

    logic        CLK = 1'b0;
    logic        RESn = 1'b0;
    logic        CE = 1'b1;
    logic        EXC_REQ = 1'b0;
    logic [15:0] EXC_CODE = '0;
    logic [31:0] EXC_PC = '0;
    logic        INT_REQ = 1'b0;
    logic [3:0]  INT_LEVEL = '0;
    logic [31:0] INT_PC = '0;
    logic        RETI_REQ = 1'b0;
    logic        EXC_ACK;
    logic        STALL;
    psw_t        PSW;
    logic [4:0]  SR_RA;
    logic [31:0] SR_RD;
    logic [4:0]  SR_WA;
    logic [31:0] SR_WD;
    logic        SR_WE;
    psw_t        PSW_SET;
    psw_t        PSW_RESET;
    logic [15:0] ECR_CC;
    logic        ECR_SET_EICC;
    logic        ECR_SET_FECC;
    logic        BR_REQ;
    logic [31:0] BR_TGT;
    logic        BR_ACK = 1'b0;
    logic        FATAL;

    always #5 CLK = ~CLK;

    v810_exc_seq dut (
        .CLK          (CLK),
        .RESn         (RESn),
        .CE           (CE),
        .EXC_REQ      (EXC_REQ),
        .EXC_CODE     (EXC_CODE),
        .EXC_PC       (EXC_PC),
        .INT_REQ      (INT_REQ),
        .INT_LEVEL    (INT_LEVEL),
        .INT_PC       (INT_PC),
        .RETI_REQ     (RETI_REQ),
        .EXC_ACK      (EXC_ACK),
        .STALL        (STALL),
        .PSW          (PSW),
        .SR_RA        (SR_RA),
        .SR_RD        (SR_RD),
        .SR_WA        (SR_WA),
        .SR_WD        (SR_WD),
        .SR_WE        (SR_WE),
        .PSW_SET      (PSW_SET),
        .PSW_RESET    (PSW_RESET),
        .ECR_CC       (ECR_CC),
        .ECR_SET_EICC (ECR_SET_EICC),
        .ECR_SET_FECC (ECR_SET_FECC),
        .BR_REQ       (BR_REQ),
        .BR_TGT       (BR_TGT),
        .BR_ACK       (BR_ACK),
        .FATAL        (FATAL)
    );

    // sysreg model
    logic [31:0] sr [0:31];
    psw_t        psw_m;
    ecr_t        ecr_m;
    logic        ld_en = 1'b0;
    psw_t        ld_psw;
    ecr_t        ld_ecr;
    logic [31:0] ld_sr [0:3];

    assign PSW   = psw_m;
    assign SR_RD = sr[SR_RA];

    // Register file model: bench preload or DUT writes
    always @(posedge CLK) begin
        if (ld_en) begin
            psw_m <= ld_psw;
            ecr_m <= ld_ecr;
            for (int k = 0; k < 4; k++)
                sr[k] <= ld_sr[k];
        end else begin
            if (SR_WE && SR_WA == SRSEL_PSW)
                psw_m <= psw_t'(SR_WD);
            else
                psw_m <= psw_t'((psw_m & ~PSW_RESET)
                                | PSW_SET);
            if (SR_WE && SR_WA != SRSEL_PSW)
                sr[SR_WA] <= SR_WD;
            if (ECR_SET_EICC) ecr_m.eicc <= ECR_CC;
            if (ECR_SET_FECC) ecr_m.fecc <= ECR_CC;
        end
    end

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic push(input string tag,
                        input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $error("FAIL sb_empty: observed %h", obs);
            return;
        end
        e = q.pop_front();
        assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h",
                   e.tag, obs, e.val);
        end
    endtask

    task automatic preset(input logic [31:0] p,
                          input logic [31:0] e,
                          input logic [31:0] r0,
                          input logic [31:0] r1,
                          input logic [31:0] r2,
                          input logic [31:0] r3);
        ld_psw   = psw_t'(p);
        ld_ecr   = ecr_t'(e);
        ld_sr[0] = r0;
        ld_sr[1] = r1;
        ld_sr[2] = r2;
        ld_sr[3] = r3;
        ld_en    = 1'b1;
        @(negedge CLK);
        ld_en    = 1'b0;
    endtask

    // accept cycle then bounded wait for BR_REQ
    task automatic accept_to_redir(output int lat);
        @(negedge CLK);
        chk(EXC_ACK);
        chk(STALL);
        EXC_REQ  = 1'b0;
        INT_REQ  = 1'b0;
        RETI_REQ = 1'b0;
        lat = 1;
        while (!BR_REQ && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic finish_redir();
        BR_ACK = 1'b1;
        @(negedge CLK);
        BR_ACK = 1'b0;
        chk(STALL);
        chk(BR_REQ);
    endtask

    initial begin
        int          lat;
        logic        seen;
        logic        ok;
        logic [31:0] tgt0;

        preset(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        push("rst_ack", 0);    chk(EXC_ACK);
        push("rst_stall", 0);  chk(STALL);
        push("rst_we", 0);     chk(SR_WE);
        push("rst_brq", 0);    chk(BR_REQ);
        push("rst_tgt", 0);    chk(BR_TGT);
        push("rst_fatal", 0);  chk(FATAL);
        push("rst_wa", 0);     chk(SR_WA);
        push("rst_ra", 0);     chk(SR_RA);
        RESn = 1'b1;
        @(negedge CLK);

        // normal exception
        push("exc_ack", 1);
        push("exc_stall", 1);
        push("exc_lat", 3);
        push("exc_tgt", 32'hFFFFFF60);
        push("exc_eipc", 32'h07000010);
        push("exc_eipsw", 32'h0);
        push("exc_eicc", 32'hFF60);
        push("exc_psw", 32'h00005000);
        push("exc_stall_end", 0);
        push("exc_brq_end", 0);
        EXC_CODE = 16'hFF60;
        EXC_PC   = 32'h07000010;
        EXC_REQ  = 1'b1;
        accept_to_redir(lat);
        chk(lat);
        chk(BR_TGT);
        chk(sr[0]);
        chk(sr[1]);
        chk(ecr_m.eicc);
        chk(psw_m);
        finish_redir();

        // interrupt accepted
        preset(32'h00030000, 32'h0, 32'h0, 32'h0,
               32'h0, 32'h0);
        push("int_ack", 1);
        push("int_stall", 1);
        push("int_lat", 3);
        push("int_tgt", 32'hFFFFFE50);
        push("int_eipc", 32'h07000200);
        push("int_eipsw", 32'h00030000);
        push("int_eicc", 32'hFE50);
        push("int_psw", 32'h00065000);
        push("int_stall_end", 0);
        push("int_brq_end", 0);
        INT_LEVEL = 4'd5;
        INT_PC    = 32'h07000200;
        INT_REQ   = 1'b1;
        accept_to_redir(lat);
        chk(lat);
        chk(BR_TGT);
        chk(sr[0]);
        chk(sr[1]);
        chk(ecr_m.eicc);
        chk(psw_m);
        finish_redir();

        // interrupt below mask level
        preset(32'h00030000, 32'h0, 32'h0, 32'h0,
               32'h0, 32'h0);
        push("int_low_none", 0);
        INT_LEVEL = 4'd2;
        INT_REQ   = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge CLK);
            seen = seen | EXC_ACK | STALL;
        end
        INT_REQ = 1'b0;
        chk(seen);

        // duplexed exception
        preset(32'h00004000, 32'h00001111, 32'h0,
               32'h0, 32'h0, 32'h0);
        push("dup_ack", 1);
        push("dup_stall", 1);
        push("dup_lat", 3);
        push("dup_tgt", 32'hFFFFFFD0);
        push("dup_fepc", 32'h07000300);
        push("dup_fepsw", 32'h00004000);
        push("dup_ecr", 32'hFF901111);
        push("dup_eipc", 32'h0);
        push("dup_psw", 32'h0000D000);
        push("dup_stall_end", 0);
        push("dup_brq_end", 0);
        EXC_CODE = 16'hFF90;
        EXC_PC   = 32'h07000300;
        EXC_REQ  = 1'b1;
        accept_to_redir(lat);
        chk(lat);
        chk(BR_TGT);
        chk(sr[2]);
        chk(sr[3]);
        chk(ecr_m);
        chk(sr[0]);
        chk(psw_m);
        finish_redir();

        // RETI with BR_ACK held off
        preset(32'h0, 32'h0, 32'h07001235,
               32'h00000004, 32'h0, 32'h0);
        push("reti_ack", 1);
        push("reti_stall", 1);
        push("reti_lat", 3);
        push("reti_psw", 32'h4);
        push("reti_tgt", 32'h07001234);
        push("reti_hold", 1);
        push("reti_stall_end", 0);
        push("reti_brq_end", 0);
        RETI_REQ = 1'b1;
        accept_to_redir(lat);
        chk(lat);
        chk(psw_m);
        chk(BR_TGT);
        tgt0 = BR_TGT;
        ok = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge CLK);
            ok = ok & BR_REQ & (BR_TGT === tgt0);
        end
        chk(ok);
        finish_redir();

        // fatal exception
        preset(32'h00008000, 32'h0, 32'h0, 32'h0,
               32'h0, 32'h0);
        push("fat_ack", 1);
        push("fat_flag", 1);
        push("fat_stall", 1);
        push("fat_quiet", 0);
        push("fat_psw", 32'h00008000);
        push("fat_rst_flag", 0);
        push("fat_rst_stall", 0);
        EXC_CODE = 16'hFF00;
        EXC_PC   = 32'h07000400;
        EXC_REQ  = 1'b1;
        @(negedge CLK);
        chk(EXC_ACK);
        chk(FATAL);
        chk(STALL);
        EXC_REQ = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge CLK);
            seen = seen | SR_WE | BR_REQ | ~FATAL
                 | ~STALL;
        end
        chk(seen);
        chk(psw_m);
        RESn = 1'b0;
        #1;
        chk(FATAL);
        chk(STALL);
        @(negedge CLK);
        RESn = 1'b1;

        // CE toggling, reset during SAVE_PSW
        preset(32'h0, 32'h22223333, 32'h0, 32'h0,
               32'h0, 32'h0);
        push("ce_wa", SRSEL_EIPSW);
        push("ce_eipc", 32'h07000500);
        push("ce_we_gated", 0);
        push("ce_set_gated", 0);
        push("ce_rst_wa", 0);
        push("ce_rst_stall", 0);
        push("ce_rst_eicc", 0);
        push("ce_ecr_kept", 32'h22223333);
        push("ce_psw_kept", 0);
        push("ce_idle", 0);
        EXC_CODE = 16'hFF70;
        EXC_PC   = 32'h07000500;
        EXC_REQ  = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge CLK);
            if (EXC_ACK) EXC_REQ = 1'b0;
            if (SR_WA == SRSEL_EIPSW) break;
            CE = ~CE;
        end
        EXC_REQ = 1'b0;
        chk(SR_WA);
        chk(sr[0]);
        CE = 1'b0;
        #1;
        chk(SR_WE);
        chk(PSW_SET);
        #1;
        RESn = 1'b0;
        #1;
        chk(SR_WA);
        chk(STALL);
        chk(ECR_SET_EICC);
        @(negedge CLK);
        RESn = 1'b1;
        CE   = 1'b1;
        repeat (5) @(negedge CLK);
        chk(ecr_m);
        chk(psw_m);
        chk(STALL);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/v810_exc_seq.md
Name: v810_exc_seq

Overview:
- Exception/interrupt sequencer for the V810 core.
- On an accepted exception, interrupt or RETI it takes the system-register write port and the dedicated PSW/ECR controls. It saves the restore PC and PSW, updates ECR and PSW, then issues a redirect to the handler vector or return address.
- Sits between the pipeline control and v810_sysreg. The pipeline is stalled while the sequence runs.

Parameters:
- FATAL_HALT, 1, 1 = a fatal (NP=1) exception enters the terminal FATAL state; 0 = treated as a duplexed exception.

Ports:
- CLK  in  1  clock
- RESn  in  1  asynchronous active-low reset
- CE  in  1  global clock enable; the FSM advances only when CE=1
- EXC_REQ  in  1  synchronous exception request (level; held until EXC_ACK)
- EXC_CODE  in  16  exception code
- EXC_PC  in  32  restore PC for the exception
- INT_REQ  in  1  maskable interrupt request (level)
- INT_LEVEL  in  4  interrupt level
- INT_PC  in  32  restore PC for the interrupt (next instruction)
- RETI_REQ  in  1  RETI executing (level; held until ACK)
- EXC_ACK  out  1  one-CE-cycle pulse: request accepted, pipeline may drop it
- STALL  out  1  pipeline must not issue LDSR or retire while high
- PSW  in  psw_t  current PSW from v810_sysreg
- SR_RA  out  5  sysreg read select
- SR_RD  in  32  sysreg read data
- SR_WA  out  5  sysreg write select
- SR_WD  out  32  sysreg write data
- SR_WE  out  1  sysreg write enable
- PSW_SET  out  psw_t  bits to set
- PSW_RESET  out  psw_t  bits to clear
- ECR_CC  out  16  cause code
- ECR_SET_EICC  out  1  load ECR.EICC
- ECR_SET_FECC  out  1  load ECR.FECC
- BR_REQ  out  1  redirect request
- BR_TGT  out  32  redirect target
- BR_ACK  in  1  fetch accepted redirect
- FATAL  out  1  core halted

Behaviour:
- Reset: RESn low asynchronously forces state IDLE and clears every output to 0, including SR_WA/SR_RA and the latched PC, code and target. Reset mid-sequence abandons the sequence; no partial write completes after reset deasserts.
- Acceptance (IDLE only, CE=1), priority EXC > RETI > INT:
  - An interrupt is accepted only if PSW.np=0, ep=0, id=0 and INT_LEVEL >= PSW.i.
  - On accept: EXC_ACK pulses; the code and PC are latched (interrupt code = 16'hFE00 | level<<4); STALL rises in the same cycle.
- Mode select at accept:
  - NP=1 → FATAL (if FATAL_HALT).
  - else EP=1 → duplexed.
  - else normal.
- States: IDLE, SAVE_PC, SAVE_PSW, REDIR, RETI_PC, RETI_PSW, FATAL.
- SAVE_PC: SR_WE=1, SR_WA = EIPC (normal) or FEPC (duplexed), SR_WD = latched PC. Next state: SAVE_PSW.
- SAVE_PSW, in a single cycle:
  - SR_WE=1, SR_WA = EIPSW or FEPSW, SR_WD = PSW.
  - Normal: ECR_SET_EICC=1; PSW_SET.ep=1, PSW_SET.id=1, PSW_RESET.ae=1.
  - Duplexed: ECR_SET_FECC=1; PSW_SET.np=1, PSW_SET.id=1, PSW_RESET.ae=1.
  - Interrupt only: PSW_RESET.i=4'hF and PSW_SET.i = min(level+1, 15).
  - ECR_CC = latched code.
  - Next state: REDIR.
- Vector target:
  - Normal: 32'hFFFF0000 | {code[15:4], 4'h0}.
  - Duplexed: 32'hFFFFFFD0.
- RETI:
  - RETI_PC: SR_RA = FEPC if PSW.np else EIPC; latch SR_RD & ~1 as target.
  - RETI_PSW: SR_RA = FEPSW or EIPSW, chosen by the np value sampled in RETI_PC; SR_WE=1, SR_WA=PSW, SR_WD=SR_RD.
  - Next state: REDIR.
- REDIR: BR_REQ=1 with BR_TGT stable until BR_ACK is sampled with CE=1, then IDLE. STALL drops on the cycle IDLE is re-entered.
- FATAL: FATAL=1 and STALL=1 until reset. PC/ECR/PSW are not modified.
- Write port: SR_WE and the PSW_SET/RESET/ECR strobes are nonzero only in the states above, and only when CE=1. Every other cycle they are 0.
- Simultaneous events: requests arriving in non-IDLE states are ignored and must be held by the requester. An EXC_REQ asserted in the same cycle as REDIR completes is accepted the following IDLE cycle.
- Latency: accept → BR_REQ is 3 CE-cycles (exception/interrupt) or 3 (RETI).

Decomposition:
- Shared package: psw_t (fields np, ep, id, ae, i[3:0]), ecr_t, and the SRSEL_* constants.
- New package constants: EXC_STATE_t enum, INT_CODE_BASE=16'hFE00, VEC_BASE=32'hFFFF0000, VEC_DUPLEX=32'hFFFFFFD0.
- One natural sub-module: v810_int_accept, a combinational mask/level compare plus the priority pick.

Test Plan:
- PSW=0, EXC_REQ code 16'hFF60, EXC_PC=0x07000010 → EIPC=0x07000010, EIPSW=0, ECR.EICC=FF60, PSW.ep=1 and id=1, BR_TGT=FFFFFF60.
- PSW.i=3, INT_LEVEL=5 → accepted with code FE50, PSW.i=6, BR_TGT=FFFFFE50. Repeat with INT_LEVEL=2 → no ACK, STALL stays 0.
- PSW.ep=1, EXC_REQ code FF90 → FEPC/FEPSW written, ECR.FECC=FF90 with EICC unchanged, PSW.np=1, BR_TGT=FFFFFFD0.
- PSW.np=1, EXC_REQ → FATAL=1, no SR_WE, state holds across 100 cycles until RESn low.
- EIPC=0x07001234, EIPSW=0x0000_0004, RETI_REQ with np=0 → PSW=4, BR_TGT=0x07001234. Hold BR_ACK low 5 cycles → BR_REQ and BR_TGT held stable.
- CE toggling 1/0 and RESn asserted during SAVE_PSW → outputs clear immediately, no ECR/PSW change afterwards, IDLE on release.
